// File: rtl/game_timer_bcd.sv
// BCD countdown game timer with selectable tick rate, pause/resume and expiry.
// Optional low-time Warn output is built only when GAME_TIMER_WARN_EN is defined.
module game_timer_bcd #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned DIGITS          = 2,
  parameter int unsigned WARN_LEVEL      = 5
) (
  input  logic                  ClockIn,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  input  logic                  Start,
  input  logic                  Pause,
  input  logic [1:0]            Speed,
  output logic [4*DIGITS-1:0]   Digits,
  output logic                  Running,
  output logic                  Tick,
  output logic                  Expired,
  output logic                  Warn
);

  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned DIV_W = (CLOCK_FREQUENCY > 2) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [DIV_W-1:0] DIV_RST =
    (CLOCK_FREQUENCY == 0) ? '0 : DIV_W'(CLOCK_FREQUENCY - 1);

  // Reject out-of-range configurations at elaboration.
  if (DIGITS < 1 || DIGITS > 8 || WARN_LEVEL > 9) begin : g_bad_cfg
    $error("game_timer_bcd: DIGITS must be 1..8 and WARN_LEVEL 0..9");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_next;
  logic [DW-1:0]    digits_q, digits_next;
  logic [DIV_W-1:0] div_q, div_next;
  logic             tick_q, tick_next;
  logic             running_q, running_next;
  logic             expired_q, expired_next;
  logic [31:0]      shifted;
  logic [DIV_W-1:0] reload_val;
  logic [DW-1:0]    digits_dec;

  // Subtract one with borrow ripple; a zero digit becomes nine and borrows.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Divider reload follows the rate selected at the moment of reload.
  always_comb begin
    shifted    = 32'(CLOCK_FREQUENCY) >> Speed;
    reload_val = (shifted == 32'd0) ? '0 : DIV_W'(shifted - 32'd1);
    digits_dec = bcd_dec(digits_q);
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      div_q     <= DIV_RST;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      digits_q  <= digits_next;
      div_q     <= div_next;
      tick_q    <= tick_next;
      running_q <= running_next;
      expired_q <= expired_next;
    end
  end

  always_comb begin
    state_next  = state_q;
    digits_next = digits_q;
    div_next    = div_q;
    tick_next   = 1'b0;

    if (Load) begin
      digits_next = bcd_clamp(LoadValue);
      div_next    = reload_val;
      state_next  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (digits_q == '0) begin
              state_next = S_EXPIRED;
            end else begin
              div_next   = reload_val;
              state_next = S_RUN;
            end
          end
        end
        S_RUN: begin
          // Start outranks Pause, and Start is a no-op while running.
          if (Pause && !Start) begin
            state_next = S_PAUSED;
          end else if (div_q == '0) begin
            div_next    = reload_val;
            digits_next = digits_dec;
            tick_next   = 1'b1;
            if (digits_dec == '0) state_next = S_EXPIRED;
          end else begin
            div_next = div_q - DIV_W'(1);
          end
        end
        S_PAUSED: begin
          if (Start) state_next = S_RUN;
        end
        S_EXPIRED: begin
          state_next = S_EXPIRED;
        end
        default: state_next = S_IDLE;
      endcase
    end

    running_next = (state_next == S_RUN);
    expired_next = (state_next == S_EXPIRED);
  end

  assign Digits  = digits_q;
  assign Tick    = tick_q;
  assign Running = running_q;
  assign Expired = expired_q;

`ifdef GAME_TIMER_WARN_EN
  localparam logic [3:0] WARN_THR = 4'(WARN_LEVEL);

  logic warn_q, warn_next;

  // Low-time flag: only digit 0 left and at or below the threshold while active.
  always_comb begin
    warn_next = 1'b0;
    if ((state_next == S_RUN || state_next == S_PAUSED) &&
        (DW'(digits_next >> 4) == '0) && (digits_next[3:0] <= WARN_THR)) begin
      warn_next = 1'b1;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) warn_q <= 1'b0;
    else       warn_q <= warn_next;
  end

  assign Warn = warn_q;
`else
  assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// Directed self-checking bench for game_timer_bcd at CLOCK_FREQUENCY=8, DIGITS=2.
module tb_game_timer_bcd;

`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic [1:0] speed;
  logic [7:0] digits;
  logic       running;
  logic       tick;
  logic       expired;
  logic       warn;

  int checks = 0;
  int errors = 0;

  game_timer_bcd #(
    .CLOCK_FREQUENCY(8),
    .DIGITS         (2),
    .WARN_LEVEL     (5)
  ) dut (
    .ClockIn  (clk),
    .Reset    (rst),
    .Load     (load),
    .LoadValue(load_value),
    .Start    (start),
    .Pause    (pause),
    .Speed    (speed),
    .Digits   (digits),
    .Running  (running),
    .Tick     (tick),
    .Expired  (expired),
    .Warn     (warn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [1:0] sp);
    load = 1'b1; load_value = v; speed = sp;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Wait for the next Tick, bounded; checks latency and the new count.
  task automatic wait_tick(input string tag, input int period, input logic [7:0] exp_digits);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    while (!seen && n < period + 4) begin
      cyc();
      n++;
      if (tick === 1'b1) seen = 1'b1;
    end
    check({tag, "_period"}, 32'(n), 32'(period));
    check({tag, "_digits"}, 32'(digits), 32'(exp_digits));
  endtask

  task automatic count_ticks(input string tag, input int cycles);
    int t;
    t = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (tick === 1'b1) t++;
    end
    check(tag, 32'(t), 32'd0);
  endtask

  initial begin
    logic [7:0] wexp;
    rst = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; speed = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_digits", 32'(digits), 32'h00);
    check("rst_running", 32'(running), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_warn", 32'(warn), 32'd0);

    // Basic countdown with borrow at 1x.
    do_load(8'h12, 2'b00);
    check("load_digits", 32'(digits), 32'h12);
    check("load_running", 32'(running), 32'd0);
    do_start();
    check("start_running", 32'(running), 32'd1);
    wait_tick("t11", 8, 8'h11);
    wait_tick("t10", 8, 8'h10);
    wait_tick("t09", 8, 8'h09);
    check("run_running", 32'(running), 32'd1);

    // Expiry on the decrement edge; Start ignored afterwards.
    do_load(8'h01, 2'b00);
    do_start();
    wait_tick("t00", 8, 8'h00);
    check("exp_same_cycle", 32'(expired), 32'd1);
    check("exp_running", 32'(running), 32'd0);
    do_start();
    count_ticks("exp_no_tick", 10);
    check("exp_hold_digits", 32'(digits), 32'h00);
    check("exp_hold_flag", 32'(expired), 32'd1);

    // Pause keeps the residual divider count; resume does not reload.
    do_load(8'h05, 2'b00);
    do_start();
    cyc(); cyc(); cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    check("pause_running", 32'(running), 32'd0);
    count_ticks("pause_no_tick", 20);
    check("pause_digits", 32'(digits), 32'h05);
    do_start();
    wait_tick("resume_1x", 5, 8'h04);

    // 8x rate: one tick per cycle, with pause and resume.
    do_load(8'h30, 2'b11);
    do_start();
    wait_tick("f29", 1, 8'h29);
    wait_tick("f28", 1, 8'h28);
    pause = 1'b1; cyc(); pause = 1'b0;
    count_ticks("fast_pause_no_tick", 20);
    do_start();
    wait_tick("f27", 1, 8'h27);

    // Clamp of non-BCD digits, and Start on an all-zero count.
    do_load(8'hAF, 2'b00);
    check("clamp_digits", 32'(digits), 32'h99);
    do_load(8'h00, 2'b00);
    do_start();
    check("zero_start_expired", 32'(expired), 32'd1);
    check("zero_start_tick", 32'(tick), 32'd0);

    // Reset on the edge where a decrement would happen.
    do_load(8'h50, 2'b00);
    do_start();
    wait_tick("r49", 8, 8'h49);
    for (int i = 0; i < 7; i++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midrst_digits", 32'(digits), 32'h00);
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_expired", 32'(expired), 32'd0);
    check("midrst_warn", 32'(warn), 32'd0);

    // Load beats a coincident decrement.
    do_load(8'h50, 2'b00);
    do_start();
    wait_tick("l49", 8, 8'h49);
    for (int i = 0; i < 7; i++) cyc();
    do_load(8'h33, 2'b00);
    check("loadwin_tick", 32'(tick), 32'd0);
    check("loadwin_digits", 32'(digits), 32'h33);
    check("loadwin_running", 32'(running), 32'd0);

    // Warn follows the ones digit near the end and drops at expiry.
    do_load(8'h07, 2'b11);
    do_start();
    check("warn_07", 32'(warn), 32'd0);
    for (int d = 6; d >= 1; d--) begin
      wexp = 8'(d);
      wait_tick("warn_step", 1, wexp);
      check("warn_level", 32'(warn), (WARN_ON && d <= 5) ? 32'd1 : 32'd0);
    end
    wait_tick("warn_end", 1, 8'h00);
    check("warn_expired", 32'(expired), 32'd1);
    check("warn_off", 32'(warn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
